// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter sharing one unified memory between fetch and data requesters.
// Data has strict priority; a watchdog completes stuck transactions; stall_cnt tracks fetch waits.
module mem_port_arbiter #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [XLEN-1:0]  i_addr,
  output logic             i_ack,
  output logic [31:0]      i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [XLEN-1:0]  d_addr,
  input  logic [XLEN-1:0]  d_wdata,
  input  logic [7:0]       d_wstrb,
  output logic             d_ack,
  output logic [XLEN-1:0]  d_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [7:0]       mem_wstrb,
  input  logic             mem_ack,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]  mem_wdata_q, mem_wdata_d;
  logic [7:0]       mem_wstrb_q, mem_wstrb_d;
  logic             sel_hi_q, sel_hi_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             busy_s;
  logic             timeout_s;
  logic             done_s;

  assign busy_s    = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign timeout_s = busy_s && !mem_ack && (wd_q == WD_W'(TIMEOUT - 1));
  assign done_s    = busy_s && (mem_ack || timeout_s);

  // Acks and read data are gated by state; a watchdog completion returns zero data.
  assign i_ack   = (state_q == BUSY_I) && (mem_ack || timeout_s);
  assign d_ack   = (state_q == BUSY_D) && (mem_ack || timeout_s);
  assign i_rdata = ((state_q == BUSY_I) && mem_ack) ?
                   (sel_hi_q ? mem_rdata[63:32] : mem_rdata[31:0]) : 32'h0000_0000;
  assign d_rdata = ((state_q == BUSY_D) && mem_ack && !mem_we_q) ? mem_rdata : {XLEN{1'b0}};

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;

  // Next-state and next-value logic for the arbiter FSM and its datapath registers.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    sel_hi_d    = sel_hi_q;
    wd_d        = wd_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = {d_addr[XLEN-1:3], 3'b000};
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_we ? d_wstrb : 8'h00;
          wd_d        = {WD_W{1'b0}};
        end else if (i_req) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {i_addr[XLEN-1:3], 3'b000};
          mem_wdata_d = {XLEN{1'b0}};
          mem_wstrb_d = 8'h00;
          sel_hi_d    = i_addr[2];
          wd_d        = {WD_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (done_s) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          wd_d      = {WD_W{1'b0}};
          err_d     = err_q | timeout_s;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        wd_d      = {WD_W{1'b0}};
      end
    endcase
  end

  // Stall counter: any cycle the fetch side is waiting, wrapping naturally.
  always_comb begin
    if (i_req && !i_ack) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {XLEN{1'b0}};
      mem_wdata_q <= {XLEN{1'b0}};
      mem_wstrb_q <= 8'h00;
      sel_hi_q    <= 1'b0;
      wd_q        <= {WD_W{1'b0}};
      err_q       <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      sel_hi_q    <= sel_hi_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT=8, CNT_W=4).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [63:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [7:0]  d_wstrb;
  logic        d_ack;
  logic [63:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        err;
  logic [3:0]  stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.XLEN(64), .TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err(err), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs;
    i_req = 1'b0; i_addr = 64'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 64'h0;
    d_wdata = 64'h0; d_wstrb = 8'h00; mem_ack = 1'b0; mem_rdata = 64'h0;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    clear_inputs();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    clear_inputs();
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req got %h exp 0", mem_req); end
    n_cmp++; if (mem_addr !== 64'h0 || mem_wdata !== 64'h0 || mem_wstrb !== 8'h00 || mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_fields got %h/%h/%h/%h exp 0", mem_addr, mem_wdata, mem_wstrb, mem_we); end
    n_cmp++; if (err !== 1'b0 || stall_cnt !== 4'd0) begin n_bad++; $display("FAIL rst_err_cnt got %h/%h exp 0/0", err, stall_cnt); end
    next_cycle();
    rst = 1'b1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h40; d_wdata = 64'h55; d_wstrb = 8'hFF;
    next_cycle();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rst_pre_busy got %h exp 1", mem_req); end
    mem_ack = 1'b1; mem_rdata = 64'h1234;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mid_mem_req got %h exp 0", mem_req); end
    n_cmp++; if (d_ack !== 1'b0 || d_rdata !== 64'h0) begin n_bad++; $display("FAIL rst_mid_d_ack got %h/%h exp 0/0", d_ack, d_rdata); end
    n_cmp++; if (mem_addr !== 64'h0 || mem_we !== 1'b0 || mem_wstrb !== 8'h00 || err !== 1'b0) begin n_bad++; $display("FAIL rst_mid_fields got %h/%h/%h/%h exp 0", mem_addr, mem_we, mem_wstrb, err); end
    clear_inputs();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_fetch;
    do_reset();
    i_req = 1'b1; i_addr = 64'h104;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || i_ack !== 1'b0) begin n_bad++; $display("FAIL fetch_c0 got %h/%h exp 0/0", mem_req, i_ack); end
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h100 || mem_we !== 1'b0 || mem_wstrb !== 8'h00) begin n_bad++; $display("FAIL fetch_mem got %h/%h/%h/%h exp 1/100/0/00", mem_req, mem_addr, mem_we, mem_wstrb); end
    n_cmp++; if (i_ack !== 1'b1 || d_ack !== 1'b0) begin n_bad++; $display("FAIL fetch_ack got %h/%h exp 1/0", i_ack, d_ack); end
    n_cmp++; if (i_rdata !== 32'hAAAA_BBBB) begin n_bad++; $display("FAIL fetch_rdata got %h exp aaaabbbb", i_rdata); end
    next_cycle();
    i_req = 1'b0; mem_ack = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || i_ack !== 1'b0 || i_rdata !== 32'h0) begin n_bad++; $display("FAIL fetch_done got %h/%h/%h exp 0/0/0", mem_req, i_ack, i_rdata); end
    n_cmp++; if (stall_cnt !== 4'd1) begin n_bad++; $display("FAIL fetch_stall got %0d exp 1", stall_cnt); end
  endtask

  task automatic test_write_wait;
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h2008; d_wdata = 64'h1122_3344_5566_7788; d_wstrb = 8'h0F;
    mem_rdata = 64'hDEAD_BEEF_0000_1111;
    next_cycle();
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) begin d_addr = 64'h3000; d_wdata = 64'h0; d_wstrb = 8'hF0; d_we = 1'b0; end
      #1;
      n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h2008 || mem_wdata !== 64'h1122_3344_5566_7788 || mem_wstrb !== 8'h0F) begin n_bad++; $display("FAIL wr_hold_c%0d got %h/%h/%h/%h/%h", c, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb); end
      n_cmp++; if (d_ack !== 1'b0 || d_rdata !== 64'h0) begin n_bad++; $display("FAIL wr_noack_c%0d got %h/%h exp 0/0", c, d_ack, d_rdata); end
      next_cycle();
    end
    mem_ack = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h2008) begin n_bad++; $display("FAIL wr_hold_c4 got %h/%h exp 1/2008", mem_req, mem_addr); end
    n_cmp++; if (d_ack !== 1'b1 || d_rdata !== 64'h0 || i_ack !== 1'b0) begin n_bad++; $display("FAIL wr_ack got %h/%h/%h exp 1/0/0", d_ack, d_rdata, i_ack); end
    next_cycle();
    d_req = 1'b0; mem_ack = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || d_ack !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL wr_done got %h/%h/%h exp 0/0/0", mem_req, d_ack, err); end
  endtask

  task automatic test_conflict;
    do_reset();
    i_req = 1'b1; i_addr = 64'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h1C; d_wdata = 64'h99; d_wstrb = 8'hFF;
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 64'h0102_0304_0506_0708;
    #1;
    n_cmp++; if (mem_addr !== 64'h18 || mem_we !== 1'b0 || mem_wstrb !== 8'h00) begin n_bad++; $display("FAIL cf_d_mem got %h/%h/%h exp 18/0/00", mem_addr, mem_we, mem_wstrb); end
    n_cmp++; if (d_ack !== 1'b1 || d_rdata !== 64'h0102_0304_0506_0708) begin n_bad++; $display("FAIL cf_d_ack got %h/%h exp 1/0102030405060708", d_ack, d_rdata); end
    n_cmp++; if (i_ack !== 1'b0 || i_rdata !== 32'h0) begin n_bad++; $display("FAIL cf_i_wait got %h/%h exp 0/0", i_ack, i_rdata); end
    next_cycle();
    d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin n_bad++; $display("FAIL cf_idle_ack got %h/%h/%h exp 0/0/0", mem_req, i_ack, d_ack); end
    n_cmp++; if (stall_cnt !== 4'd2) begin n_bad++; $display("FAIL cf_stall_mid got %0d exp 2", stall_cnt); end
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    #1;
    n_cmp++; if (mem_addr !== 64'h200 || mem_we !== 1'b0 || mem_req !== 1'b1) begin n_bad++; $display("FAIL cf_i_mem got %h/%h/%h exp 200/0/1", mem_addr, mem_we, mem_req); end
    n_cmp++; if (i_ack !== 1'b1 || i_rdata !== 32'h3333_4444) begin n_bad++; $display("FAIL cf_i_ack got %h/%h exp 1/33334444", i_ack, i_rdata); end
    next_cycle();
    i_req = 1'b0; mem_ack = 1'b0;
    #1;
    n_cmp++; if (stall_cnt !== 4'd3) begin n_bad++; $display("FAIL cf_stall got %0d exp 3", stall_cnt); end
  endtask

  task automatic test_watchdog;
    do_reset();
    i_req = 1'b1; i_addr = 64'h8;
    mem_rdata = 64'hCAFE_F00D_1234_5678;
    next_cycle();
    for (int c = 1; c <= 7; c++) begin
      #1;
      n_cmp++; if (i_ack !== 1'b0 || mem_req !== 1'b1) begin n_bad++; $display("FAIL wd_wait_c%0d got %h/%h exp 0/1", c, i_ack, mem_req); end
      next_cycle();
    end
    #1;
    n_cmp++; if (i_ack !== 1'b1 || i_rdata !== 32'h0) begin n_bad++; $display("FAIL wd_fire got %h/%h exp 1/0", i_ack, i_rdata); end
    next_cycle();
    i_req = 1'b0;
    #1;
    n_cmp++; if (err !== 1'b1 || mem_req !== 1'b0) begin n_bad++; $display("FAIL wd_err got %h/%h exp 1/0", err, mem_req); end
    n_cmp++; if (stall_cnt !== 4'd8) begin n_bad++; $display("FAIL wd_stall got %0d exp 8", stall_cnt); end
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h30;
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 64'h0BAD_C0DE_0000_0042;
    #1;
    n_cmp++; if (d_ack !== 1'b1 || d_rdata !== 64'h0BAD_C0DE_0000_0042 || mem_addr !== 64'h30) begin n_bad++; $display("FAIL wd_next got %h/%h/%h exp 1/0badc0de00000042/30", d_ack, d_rdata, mem_addr); end
    next_cycle();
    d_req = 1'b0; mem_ack = 1'b0;
    #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL wd_sticky got %h exp 1", err); end
  endtask

  task automatic test_stall_wrap;
    do_reset();
    i_req = 1'b1; i_addr = 64'h400;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h500; d_wdata = 64'h77; d_wstrb = 8'h01;
    mem_ack = 1'b1; mem_rdata = 64'h0;
    for (int c = 0; c < 16; c++) begin
      #1;
      n_cmp++; if (i_ack !== 1'b0) begin n_bad++; $display("FAIL wrap_no_iack_c%0d got %h exp 0", c, i_ack); end
      if (c == 15) begin
        n_cmp++; if (stall_cnt !== 4'd15) begin n_bad++; $display("FAIL wrap_pre got %0d exp 15", stall_cnt); end
      end
      next_cycle();
    end
    clear_inputs();
    #1;
    n_cmp++; if (stall_cnt !== 4'd0) begin n_bad++; $display("FAIL wrap_zero got %0d exp 0", stall_cnt); end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_fetch();
    test_write_wait();
    test_conflict();
    test_watchdog();
    test_stall_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
